// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous display update.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN darkens leading-zero digits.
module seg_scan_ctrl #(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   upd_data,
  input  logic [DIGITS-1:0]     upd_dp,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  output logic [3:0]            rom_a,
  input  logic [7:0]            rom_spo,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned IdxW  = $clog2(DIGITS);
  localparam int unsigned TickW = $clog2(SCAN_DIV);

  typedef enum logic {StBlank, StShow} state_e;

  state_e              state_q, state_d;
  logic [TickW-1:0]    tick_q, tick_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d, pend_q, pend_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d, pend_dp_q, pend_dp_d;
  logic                pend_v_q, pend_v_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          seg_q, seg_d;
  logic [3:0]          rom_a_q, rom_a_d;

  logic wrap, show_edge, last_digit;
  logic unused_spo;

  assign wrap       = (tick_q == TickW'(SCAN_DIV - 1));
  assign show_edge  = (state_q == StBlank) && (tick_q == TickW'(BLANK_CYC - 1));
  assign last_digit = (idx_q == IdxW'(DIGITS - 1));
  assign unused_spo = rom_spo[7];

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // High when this digit and every more-significant digit are zero.
  logic upper_zero;
  always_comb begin
    upper_zero = 1'b1;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if ((k >= int'(idx_q)) && (shadow_q[4*k +: 4] != 4'h0)) upper_zero = 1'b0;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    tick_d      = wrap ? '0 : tick_q + 1'b1;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    pend_d      = pend_q;
    pend_dp_d   = pend_dp_q;
    pend_v_d    = pend_v_q;
    an_d        = an_q;
    seg_d       = seg_q;
    rom_a_d     = rom_a_q;

    if (upd_valid && !pend_v_q) begin
      pend_d    = upd_data;
      pend_dp_d = upd_dp;
      pend_v_d  = 1'b1;
    end

    if (wrap) begin
      idx_d   = last_digit ? '0 : idx_q + 1'b1;
      state_d = StBlank;
      an_d    = '1;
      // Frame boundary: swap in pending data so the next frame is coherent.
      if (last_digit && pend_v_q) begin
        shadow_d    = pend_q;
        shadow_dp_d = pend_dp_q;
        pend_v_d    = 1'b0;
      end
      rom_a_d = shadow_d[4*idx_d +: 4];
    end

    if (show_edge) begin
      state_d = StShow;
      seg_d   = {~shadow_dp_q[idx_q], rom_spo[6:0]};
      an_d    = '1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (!((idx_q != '0) && upper_zero)) an_d[idx_q] = 1'b0;
`else
      an_d[idx_q] = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StBlank;
      tick_q      <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      pend_q      <= '0;
      pend_dp_q   <= '0;
      pend_v_q    <= 1'b0;
      an_q        <= '1;
      seg_q       <= 8'hFF;
      rom_a_q     <= 4'h0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      pend_q      <= pend_d;
      pend_dp_q   <= pend_dp_d;
      pend_v_q    <= pend_v_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      rom_a_q     <= rom_a_d;
    end
  end

  assign upd_ready = ~pend_v_q;
  assign rom_a     = rom_a_q;
  assign seg       = seg_q;
  assign an        = an_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: cycle-count reference model plus spot checks.
// Honours SEG_LEADING_ZERO_BLANK_EN when the build defines it.
module tb_seg_scan_ctrl;

  localparam int D = 8;
  localparam int S = 8;
  localparam int B = 2;
  localparam int F = D * S;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] upd_data;
  logic [7:0]  upd_dp;
  logic        upd_valid;
  logic        upd_ready;
  logic [3:0]  rom_a;
  logic [7:0]  rom_spo;
  logic [7:0]  seg;
  logic [7:0]  an;

  int tests = 0;
  int fails = 0;

  // Reference model state: cycles since reset, displayed/pending data, held cathodes.
  int unsigned t = 0;
  logic [31:0] m_sh = '0, m_pend = '0;
  logic [7:0]  m_shdp = '0, m_penddp = '0, m_seg = 8'hFF;
  bit          m_pv = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom7(input logic [3:0] n);
    case (n)
      4'h0: rom7 = 8'hC0; 4'h1: rom7 = 8'hF9; 4'h2: rom7 = 8'hA4; 4'h3: rom7 = 8'hB0;
      4'h4: rom7 = 8'h99; 4'h5: rom7 = 8'h92; 4'h6: rom7 = 8'h82; 4'h7: rom7 = 8'hF8;
      4'h8: rom7 = 8'h80; 4'h9: rom7 = 8'h90; 4'hA: rom7 = 8'h88; 4'hB: rom7 = 8'h83;
      4'hC: rom7 = 8'hC6; 4'hD: rom7 = 8'hA1; 4'hE: rom7 = 8'h86; default: rom7 = 8'h8E;
    endcase
  endfunction

  assign rom_spo = rom7(rom_a);

  seg_scan_ctrl #(.DIGITS(D), .SCAN_DIV(S), .BLANK_CYC(B)) dut (
    .clk       (clk),
    .rst       (rst),
    .upd_data  (upd_data),
    .upd_dp    (upd_dp),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .rom_a     (rom_a),
    .rom_spo   (rom_spo),
    .seg       (seg),
    .an        (an)
  );

  // Expected {an, seg, rom_a, upd_ready} from the cycle position and model data.
  function automatic logic [20:0] exp_vec();
    int unsigned pos, dig;
    logic [7:0]  a;
    bit          lit;
    pos = t % S;
    dig = (t / S) % D;
    a   = 8'hFF;
    lit = (pos >= B);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (dig != 0 && (m_sh >> (4 * dig)) == 32'd0) lit = 1'b0;
`endif
    if (lit) a[dig] = 1'b0;
    exp_vec = {a, m_seg, m_sh[4*dig +: 4], !m_pv};
  endfunction

  // Advance one clock and apply the spec's edge rules to the model.
  task automatic cyc();
    bit          r, v;
    logic [31:0] d;
    logic [7:0]  dp;
    int unsigned pos, dig;
    r = rst; v = upd_valid; d = upd_data; dp = upd_dp;
    @(posedge clk);
    #1;
    if (r) begin
      t = 0; m_sh = '0; m_shdp = '0; m_pv = 1'b0; m_seg = 8'hFF;
    end else begin
      pos = t % S;
      dig = (t / S) % D;
      if (pos == B - 1) begin
        m_seg    = rom7(m_sh[4*dig +: 4]);
        m_seg[7] = ~m_shdp[dig];
      end
      if (((t + 1) % F) == 0 && m_pv) begin
        m_sh = m_pend; m_shdp = m_penddp; m_pv = 1'b0;
      end else if (v && !m_pv) begin
        m_pend = d; m_penddp = dp; m_pv = 1'b1;
      end
      t++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; upd_valid = 1'b0; upd_data = '0; upd_dp = '0;
    repeat (3) begin
      cyc();
      tests++;
      if (an !== 8'hFF || seg !== 8'hFF || rom_a !== 4'h0 || upd_ready !== 1'b1) begin
        fails++;
        $display("FAIL reset_hold an=%h seg=%h rom_a=%h rdy=%b want FF FF 0 1",
                 an, seg, rom_a, upd_ready);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      tests++;
      if (i < 2) begin
        if (an !== 8'hFF || seg !== 8'hFF || upd_ready !== 1'b1) begin
          fails++;
          $display("FAIL reset_blank i=%0d an=%h seg=%h rdy=%b want FF FF 1",
                   i, an, seg, upd_ready);
        end
      end else if (an !== 8'hFE || seg !== 8'hC0 || upd_ready !== 1'b1) begin
        fails++;
        $display("FAIL reset_first_show i=%0d an=%h seg=%h rdy=%b want FE C0 1",
                 i, an, seg, upd_ready);
      end
    end
  endtask

  task automatic test_update();
    int unsigned fa;
    while (t % F != 20) begin
      cyc();
      tests++;
      if ({an, seg, rom_a, upd_ready} !== exp_vec()) begin
        fails++;
        $display("FAIL update_pre t=%0d got an=%h seg=%h rom_a=%h rdy=%b want %h",
                 t, an, seg, rom_a, upd_ready, exp_vec());
      end
    end
    upd_valid = 1'b1; upd_data = 32'h89ABCDEF; upd_dp = 8'h01;
    cyc();
    upd_valid = 1'b0; upd_data = $urandom; upd_dp = 8'($urandom);
    fa = t / F;
    for (int i = 0; i < 2 * F; i++) begin
      cyc();
      tests++;
      if ({an, seg, rom_a, upd_ready} !== exp_vec()) begin
        fails++;
        $display("FAIL update t=%0d got an=%h seg=%h rom_a=%h rdy=%b want %h",
                 t, an, seg, rom_a, upd_ready, exp_vec());
      end
      if (t == (fa + 1) * F + 2) begin
        tests++;
        if (seg !== 8'h0E || an !== 8'hFE) begin
          fails++;
          $display("FAIL update_digit0 seg=%h an=%h want 0E FE", seg, an);
        end
      end
      if (t == (fa + 1) * F + 7 * S + 2) begin
        tests++;
        if (seg !== 8'h80 || an !== 8'h7F) begin
          fails++;
          $display("FAIL update_digit7 seg=%h an=%h want 80 7F", seg, an);
        end
      end
    end
  endtask

  task automatic test_hold_valid();
    int unsigned f;
    while (t % F != 10) cyc();
    upd_valid = 1'b1; upd_data = 32'h12345678; upd_dp = 8'h00;
    cyc();
    f = t / F;
    upd_data = 32'hCAFE0042; upd_dp = 8'hF0;
    while (t < (f + 3) * F) begin
      if (t >= (f + 1) * F + 2) upd_valid = 1'b0;
      cyc();
      tests++;
      if ({an, seg, rom_a, upd_ready} !== exp_vec()) begin
        fails++;
        $display("FAIL hold_valid t=%0d got an=%h seg=%h rom_a=%h rdy=%b want %h",
                 t, an, seg, rom_a, upd_ready, exp_vec());
      end
      if (t == (f + 1) * F + 2 || t == (f + 2) * F + 2) begin
        tests++;
        if (seg !== ((t == (f + 1) * F + 2) ? 8'h80 : 8'hA4)) begin
          fails++;
          $display("FAIL hold_valid_digit0 t=%0d seg=%h", t, seg);
        end
      end
    end
  endtask

  task automatic test_boundary_accept();
    int unsigned f;
    while (t % F != F - 1) cyc();
    upd_valid = 1'b1; upd_data = 32'h000000A5; upd_dp = 8'h00;
    cyc();
    upd_valid = 1'b0;
    f = t / F;
    while (t < (f + 2) * F) begin
      cyc();
      tests++;
      if ({an, seg, rom_a, upd_ready} !== exp_vec()) begin
        fails++;
        $display("FAIL boundary t=%0d got an=%h seg=%h rom_a=%h rdy=%b want %h",
                 t, an, seg, rom_a, upd_ready, exp_vec());
      end
      if (t == f * F + 2 || t == (f + 1) * F + 2) begin
        tests++;
        if (seg !== ((t == f * F + 2) ? 8'hA4 : 8'h92)) begin
          fails++;
          $display("FAIL boundary_digit0 t=%0d seg=%h", t, seg);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    while (t % F != 24) cyc();
    upd_valid = 1'b1; upd_data = 32'h77777777; upd_dp = 8'hFF;
    cyc();
    upd_valid = 1'b0;
    while (t % F != 5 * S + 4) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    tests++;
    if (an !== 8'hFF || upd_ready !== 1'b1 || seg !== 8'hFF) begin
      fails++;
      $display("FAIL reset_mid an=%h rdy=%b seg=%h want FF 1 FF", an, upd_ready, seg);
    end
    for (int i = 0; i < 2 * F; i++) begin
      cyc();
      tests++;
      if ({an, seg, rom_a, upd_ready} !== exp_vec()) begin
        fails++;
        $display("FAIL reset_mid_scan t=%0d got an=%h seg=%h rom_a=%h rdy=%b want %h",
                 t, an, seg, rom_a, upd_ready, exp_vec());
      end
    end
  endtask

  task automatic test_leading_zero();
    int unsigned f;
    while (t % F != 30) cyc();
    upd_valid = 1'b1; upd_data = 32'h00000102; upd_dp = 8'h00;
    cyc();
    upd_valid = 1'b0;
    f = t / F;
    while (t < (f + 2) * F) begin
      cyc();
      tests++;
      if ({an, seg, rom_a, upd_ready} !== exp_vec()) begin
        fails++;
        $display("FAIL leading_zero t=%0d got an=%h seg=%h rom_a=%h rdy=%b want %h",
                 t, an, seg, rom_a, upd_ready, exp_vec());
      end
      if (t == (f + 1) * F + 5 * S + 4) begin
        tests++;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (an !== 8'hFF) begin
`else
        if (an !== 8'hDF) begin
`endif
          fails++;
          $display("FAIL leading_zero_digit5 an=%h", an);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4 * F; i++) begin
      upd_valid = ($urandom_range(0, 7) == 0);
      upd_data  = $urandom;
      upd_dp    = 8'($urandom);
      cyc();
      tests++;
      if ({an, seg, rom_a, upd_ready} !== exp_vec()) begin
        fails++;
        $display("FAIL random t=%0d got an=%h seg=%h rom_a=%h rdy=%b want %h",
                 t, an, seg, rom_a, upd_ready, exp_vec());
      end
    end
    upd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_update();
    test_hold_valid();
    test_boundary_accept();
    test_reset_mid();
    test_leading_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
